// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern generator.
// The state encoding here is also mirrored as plain localparams in the top module.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  localparam int DEF_PAT_W   = 8;
  localparam int DEF_CLK_DIV = 4;
  localparam int DEF_LEN_W   = 4;

  // A length is usable only if it selects at least one bit and fits the pattern.
  function automatic logic len_is_legal(input int unsigned len, input int unsigned pat_w);
    return (len >= 1) && (len <= pat_w);
  endfunction

endpackage

// File: rtl/seq_bit_timer.sv
// Bit-period divider: counts 0..CLK_DIV-1 while enabled.
// tick marks the last system clock of each serial bit.
module seq_bit_timer
  import seq_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic system_clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (tick) begin
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/seq_generator_fsm.sv
// Serial pattern transmitter: shifts a latched pattern out MSB first with a
// per-bit strobe, in single-shot or continuous-repeat mode with graceful stop.
module seq_generator_fsm
  import seq_pkg::*;
#(
  parameter int PAT_W   = DEF_PAT_W,
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic             system_clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             repeat_mode,
  input  logic             stop,
  output logic             x,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_SEND = SEND;
  localparam logic [1:0] ST_DONE = DONE;

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("seq_generator_fsm: CLK_DIV must be at least 1");
  end
  if ((2 ** LEN_W) <= PAT_W) begin : g_bad_len_w
    $error("seq_generator_fsm: LEN_W too narrow to express PAT_W");
  end

  logic [1:0]       state;
  logic [PAT_W-1:0] shadow_pat;
  logic [LEN_W-1:0] shadow_len;
  logic [LEN_W-1:0] idx;
  logic             stop_flag;
  logic             tick;
  logic             start_ok;
  logic             last_bit;
  logic             x_bit;

  assign start_ok = start && len_is_legal(32'(len), PAT_W);
  assign last_bit = ({1'b0, idx} + (LEN_W + 1)'(1)) >= {1'b0, shadow_len};

  seq_bit_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_timer (
    .system_clk(system_clk),
    .reset     (reset),
    .clear     (state != ST_SEND),
    .enable    (state == ST_SEND),
    .tick      (tick)
  );

  // A stop seen at any point in a bit period (including its final cycle) ends
  // the transmission once that bit has completed, overriding repeat.
  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      shadow_pat <= '0;
      shadow_len <= '0;
      idx        <= '0;
      stop_flag  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            shadow_pat <= pattern;
            shadow_len <= len;
            idx        <= '0;
            stop_flag  <= 1'b0;
            state      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (stop) begin
            stop_flag <= 1'b1;
          end
          if (tick) begin
            if (stop_flag || stop) begin
              state <= ST_DONE;
            end else if (!last_bit) begin
              idx <= idx + LEN_W'(1);
            end else if (repeat_mode) begin
              idx <= '0;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    x_bit = 1'b0;
    for (int i = 0; i < PAT_W; i++) begin
      if (idx == LEN_W'(PAT_W - 1 - i)) begin
        x_bit = shadow_pat[i];
      end
    end
  end

  assign x         = (state == ST_SEND) && x_bit;
  assign bit_valid = (state == ST_SEND) && tick;
  assign busy      = (state == ST_SEND);
  assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_seq_generator_fsm.sv
// Directed bench for seq_generator_fsm: a vector table for single-shot, illegal
// length and start-while-busy, then hand sequences for repeat/stop, reset and CLK_DIV=1.
module tb_seq_generator_fsm;

  logic       system_clk = 1'b0;
  logic       reset;
  logic       start, repeat_mode, stop;
  logic [7:0] pattern;
  logic [3:0] len;
  logic       x, bit_valid, busy, done;

  logic       start1, rep1, stop1;
  logic [7:0] pattern1;
  logic [3:0] len1;
  logic       x1, bv1, busy1, done1;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic       start;
    logic [7:0] pattern;
    logic [3:0] len;
    logic       rep;
    logic       stop;
    logic       ex;
    logic       ebv;
    logic       ebusy;
    logic       edone;
  } vec_t;

  vec_t vecs[$];

  logic [1:18] ss_x  = 18'b111111110000111100;
  logic [1:18] ss_bv = 18'b000100010001000100;
  logic [1:18] ss_bz = 18'b111111111111111100;
  logic [1:18] ss_dn = 18'b000000000000000010;
  logic [7:0]  pat_a5 = 8'hA5;
  logic [3:0]  rep_bits = 4'b1101;
  logic [1:4]  div1_bits = 4'b1011;

  always #5 system_clk = ~system_clk;

  seq_generator_fsm #(.PAT_W(8), .CLK_DIV(4), .LEN_W(4)) dut (
    .system_clk (system_clk),
    .reset      (reset),
    .start      (start),
    .pattern    (pattern),
    .len        (len),
    .repeat_mode(repeat_mode),
    .stop       (stop),
    .x          (x),
    .bit_valid  (bit_valid),
    .busy       (busy),
    .done       (done)
  );

  seq_generator_fsm #(.PAT_W(8), .CLK_DIV(1), .LEN_W(4)) dut1 (
    .system_clk (system_clk),
    .reset      (reset),
    .start      (start1),
    .pattern    (pattern1),
    .len        (len1),
    .repeat_mode(rep1),
    .stop       (stop1),
    .x          (x1),
    .bit_valid  (bv1),
    .busy       (busy1),
    .done       (done1)
  );

  task automatic step();
    @(posedge system_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0b, expected %0b", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic ex, input logic ebv,
                          input logic ebusy, input logic edone);
    checkOutput({tag, " x"}, x, ex);
    checkOutput({tag, " bit_valid"}, bit_valid, ebv);
    checkOutput({tag, " busy"}, busy, ebusy);
    checkOutput({tag, " done"}, done, edone);
  endtask

  task automatic checkAll1(input string tag, input logic ex, input logic ebv,
                           input logic ebusy, input logic edone);
    checkOutput({tag, " x"}, x1, ex);
    checkOutput({tag, " bit_valid"}, bv1, ebv);
    checkOutput({tag, " busy"}, busy1, ebusy);
    checkOutput({tag, " done"}, done1, edone);
  endtask

  task automatic applyStimulus(input vec_t v);
    start       = v.start;
    pattern     = v.pattern;
    len         = v.len;
    repeat_mode = v.rep;
    stop        = v.stop;
  endtask

  task automatic addVec(input logic s, input logic [7:0] p, input logic [3:0] l,
                        input logic r, input logic sp, input logic ex, input logic ebv,
                        input logic ebusy, input logic edone);
    vec_t v;
    v.start = s;   v.pattern = p; v.len = l; v.rep = r; v.stop = sp;
    v.ex = ex;     v.ebv = ebv;   v.ebusy = ebusy;      v.edone = edone;
    vecs.push_back(v);
  endtask

  initial begin
    // Entry j drives the inputs sampled at edge j; its expectations are for cycle j+1.
    for (int j = 0; j < 18; j++) begin
      addVec(j == 0, 8'b1101_0000, 4'd4, 1'b0, 1'b0,
             ss_x[j+1], ss_bv[j+1], ss_bz[j+1], ss_dn[j+1]);
    end
    addVec(1'b1, 8'hFF, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    addVec(1'b0, 8'hFF, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    addVec(1'b1, 8'hFF, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    addVec(1'b0, 8'hFF, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 34; j++) begin
      int c;
      c = j + 1;
      addVec((j == 0) || (j == 10), (j == 10) ? 8'hFF : 8'hA5, (j == 10) ? 4'd2 : 4'd8,
             1'b0, 1'b0,
             (c <= 32) ? pat_a5[7 - (c - 1) / 4] : 1'b0,
             (c <= 32) && (c % 4 == 0), c <= 32, c == 33);
    end

    reset = 1'b1;
    start = 1'b0; pattern = '0; len = '0; repeat_mode = 1'b0; stop = 1'b0;
    start1 = 1'b0; pattern1 = '0; len1 = '0; rep1 = 1'b0; stop1 = 1'b0;
    step();
    step();
    checkAll("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    checkAll1("reset div1", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      step();
      checkAll($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ebv, vecs[i].ebusy, vecs[i].edone);
    end

    $display("[TB] repeat then stop");
    for (int e = 0; e <= 41; e++) begin
      int c;
      start = (e == 0); pattern = 8'b1101_0000; len = 4'd4; repeat_mode = 1'b1;
      stop = (e == 38);
      step();
      c = e + 1;
      if (c <= 40)
        checkAll($sformatf("rpt c%0d", c), rep_bits[3 - ((c - 1) / 4) % 4], c % 4 == 0, 1'b1, 1'b0);
      else
        checkAll($sformatf("rpt c%0d", c), 1'b0, 1'b0, 1'b0, c == 41);
    end
    repeat_mode = 1'b0;
    stop = 1'b0;

    $display("[TB] reset mid-send");
    for (int e = 0; e <= 5; e++) begin
      start = (e == 0); pattern = 8'b1101_0000; len = 4'd4;
      step();
    end
    checkAll("pre-reset c6", 1'b1, 1'b0, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkAll("async reset", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkAll("held reset", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int e = 0; e <= 8; e++) begin
      int c;
      start = (e == 0); pattern = 8'h80; len = 4'd2;
      step();
      c = e + 1;
      checkAll($sformatf("post-reset c%0d", c), c <= 4, (c == 4) || (c == 8), c <= 8, c == 9);
    end
    start = 1'b0;

    $display("[TB] CLK_DIV=1 build");
    for (int e = 0; e <= 5; e++) begin
      int c;
      start1 = (e == 0); pattern1 = 8'b1011_0000; len1 = 4'd4;
      step();
      c = e + 1;
      checkAll1($sformatf("div1 c%0d", c), (c <= 4) ? div1_bits[c] : 1'b0, c <= 4, c <= 4, c == 5);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
